// File: rtl/uart_rx_core_pkg.sv
// Shared constants and state encoding for the 16x oversampling 8N1 UART receiver.
package uart_rx_core_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] MID_COUNT  = 4'(MID_START);
  localparam logic [3:0] LAST_COUNT = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/rx_sample_counter.sv
// Free-running 4-bit oversample counter; advances and clears only on enable ticks.
module rx_sample_counter
  import uart_rx_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_ce,
  input  logic       clear,
  output logic [3:0] count,
  output logic       tick7,
  output logic       tick15
);

  // Sample counter, wraps 15 -> 0 naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (uart_ce) begin
      if (clear) begin
        count <= 4'd0;
      end else begin
        count <= count + 4'd1;
      end
    end else begin
      count <= count;
    end
  end

  assign tick7  = (count == MID_COUNT);
  assign tick15 = (count == LAST_COUNT);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver core: synchronizes RXD, mid-bit samples at 16x oversampling,
// reports framed bytes and stop-bit errors as single-cycle pulses.
module uart_rx_core
  import uart_rx_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_ce,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy
);

  logic       sync1_r;
  logic       sync2_r;
  logic       line_s;
  logic       clear_s;
  logic [3:0] count_s;
  logic       tick7_s;
  logic       tick15_s;
  state_t     state_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shift_r;

  // Two-flop synchronizer, idles high so reset does not look like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rxd;
      sync2_r <= sync1_r;
    end
  end

  assign line_s = sync2_r;

  // Counter restarts at start detection and again at mid-start, so every later
  // sample lands on count 15, i.e. one full bit period apart.
  always_comb begin
    clear_s = 1'b0;
    if ((state_r == ST_IDLE) && !line_s) begin
      clear_s = 1'b1;
    end else if ((state_r == ST_START) && tick7_s) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
  end

  rx_sample_counter u_sample_counter (
    .clk     (clk),
    .rst     (rst),
    .uart_ce (uart_ce),
    .clear   (clear_s),
    .count   (count_s),
    .tick7   (tick7_s),
    .tick15  (tick15_s)
  );

  // Receive FSM with registered data, pulse and busy outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (uart_ce) begin
        case (state_r)
          ST_IDLE: begin
            if (!line_s) begin
              state_r <= ST_START;
              rx_busy <= 1'b1;
            end
          end
          ST_START: begin
            if (tick7_s) begin
              if (!line_s) begin
                state_r   <= ST_DATA;
                bit_idx_r <= 3'd0;
              end else begin
                state_r <= ST_IDLE;
                rx_busy <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (tick15_s) begin
              shift_r[bit_idx_r] <= line_s;
              if (bit_idx_r == LAST_BIT) begin
                state_r <= ST_STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end
          end
          ST_STOP: begin
            if (tick15_s) begin
              if (line_s) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
                state_r  <= ST_IDLE;
                rx_busy  <= 1'b0;
              end else begin
                rx_ferr <= 1'b1;
                state_r <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (line_s) begin
              state_r <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: nominal, back-to-back, glitch, break,
// mid-frame reset and baud-offset frames with hand-computed expectations.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_ce;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int both_cnt    = 0;
  logic [7:0] got_q[$];
  logic [7:0] b;

  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk      (clk),
    .rst      (rst),
    .uart_ce  (uart_ce),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_busy  (rx_busy)
  );

  // 16x enable: one clk cycle high out of every four
  initial begin
    uart_ce = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      uart_ce = 1'b1;
      @(negedge clk);
      uart_ce = 1'b0;
    end
  end

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
    end
    if (rx_ferr) ferr_cnt++;
    if (rx_valid && rx_ferr) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_byte(output logic [7:0] nb);
    if (got_q.size() > 0) nb = got_q.pop_front();
    else nb = 8'hxx;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame, bit period given in clk cycles (64 = 16 ticks); line left at stop level
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per);
    rxd = 1'b0;
    wait_clks(per);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clks(per);
    end
    rxd = stop_bit;
    wait_clks(per);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    wait_clks(3);
    check("rst_data",  32'(rx_data),  32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr",  32'(rx_ferr),  32'd0);
    check("rst_busy",  32'(rx_busy),  32'd0);
    rst = 1'b0;
    wait_clks(20);

    // Nominal 0x55
    send_frame(8'h55, 1'b1, 64);
    rxd = 1'b1;
    wait_clks(100);
    check("f55_count", 32'(valid_cnt), 32'd1);
    next_byte(b);
    check("f55_byte", 32'(b), 32'h55);
    check("f55_hold", 32'(rx_data), 32'h55);
    check("f55_ferr", 32'(ferr_cnt), 32'd0);
    check("f55_idle", 32'(rx_busy), 32'd0);

    // Back-to-back 0xA3, 0x0F with no idle gap
    send_frame(8'hA3, 1'b1, 64);
    send_frame(8'h0F, 1'b1, 64);
    rxd = 1'b1;
    wait_clks(100);
    check("b2b_count", 32'(valid_cnt), 32'd3);
    next_byte(b);
    check("b2b_first", 32'(b), 32'hA3);
    next_byte(b);
    check("b2b_second", 32'(b), 32'h0F);

    // Start glitch: 4 ticks low
    rxd = 1'b0;
    wait_clks(16);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    wait_clks(60);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check("glitch_valid", 32'(valid_cnt), 32'd3);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);

    // 0xFF with bad stop, line low 40 ticks from stop bit start
    send_frame(8'hFF, 1'b0, 64);
    rxd = 1'b0;
    wait_clks(96);
    check("brk_ferr", 32'(ferr_cnt), 32'd1);
    check("brk_valid", 32'(valid_cnt), 32'd3);
    check("brk_data", 32'(rx_data), 32'h0F);
    check("brk_busy", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    wait_clks(20);
    check("brk_exit", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 1'b1, 64);
    rxd = 1'b1;
    wait_clks(100);
    check("brk_next_count", 32'(valid_cnt), 32'd4);
    next_byte(b);
    check("brk_next_byte", 32'(b), 32'h12);

    // Reset after the third data bit of 0x81
    rxd = 1'b0;
    wait_clks(64);
    rxd = 1'b1;
    wait_clks(64);
    rxd = 1'b0;
    wait_clks(128);
    check("mid_busy_pre", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    wait_clks(2);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_ferr", 32'(rx_ferr), 32'd0);
    rxd = 1'b1;
    rst = 1'b0;
    wait_clks(300);
    check("mid_no_valid", 32'(valid_cnt), 32'd4);
    check("mid_no_ferr", 32'(ferr_cnt), 32'd1);
    check("mid_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h3C, 1'b1, 64);
    rxd = 1'b1;
    wait_clks(100);
    next_byte(b);
    check("mid_next_byte", 32'(b), 32'h3C);

    // Baud offset: 15.5 and 16.5 ticks per bit
    send_frame(8'hC6, 1'b1, 62);
    rxd = 1'b1;
    wait_clks(100);
    next_byte(b);
    check("fast_byte", 32'(b), 32'hC6);
    send_frame(8'hC6, 1'b1, 66);
    rxd = 1'b1;
    wait_clks(100);
    next_byte(b);
    check("slow_byte", 32'(b), 32'hC6);
    check("baud_ferr", 32'(ferr_cnt), 32'd1);
    check("total_valid", 32'(valid_cnt), 32'd7);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
